// File: rtl/sec_timer_pkg.sv
// Shared types and BCD limits for the seconds timer.
// The clamp helper maps any non-BCD or out-of-range seconds value onto 59.
package sec_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] SEC_MAX_BCD = 8'h59;
  localparam logic [3:0] UNITS_MAX   = 4'd9;
  localparam logic [3:0] TENS_MAX    = 4'd5;

  function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
    logic [7:0] r;
    if ((v[7:4] > TENS_MAX) || (v[3:0] > UNITS_MAX)) begin
      r = SEC_MAX_BCD;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_sec_cnt.sv
// Two-digit BCD seconds counter (00..59) with load, enable and direction.
// at_one flags the value from which the next down step lands on 00.
module bcd_sec_cnt
  import sec_timer_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  input  logic       down,
  output logic [7:0] cnt,
  output logic       at_one
);

  logic [7:0] cnt_r;
  logic [7:0] next_s;

  // Next BCD value one step up or down, wrapping inside 00..59
  always_comb begin
    next_s = cnt_r;
    if (down) begin
      if (cnt_r == 8'h00) begin
        next_s = SEC_MAX_BCD;
      end else if (cnt_r[3:0] == 4'd0) begin
        next_s = {cnt_r[7:4] - 4'd1, UNITS_MAX};
      end else begin
        next_s = {cnt_r[7:4], cnt_r[3:0] - 4'd1};
      end
    end else begin
      if (cnt_r == SEC_MAX_BCD) begin
        next_s = 8'h00;
      end else if (cnt_r[3:0] == UNITS_MAX) begin
        next_s = {cnt_r[7:4] + 4'd1, 4'd0};
      end else begin
        next_s = {cnt_r[7:4], cnt_r[3:0] + 4'd1};
      end
    end
  end

  // Count register: clear beats load beats step
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_r <= 8'h00;
    end else if (clr) begin
      cnt_r <= 8'h00;
    end else if (load) begin
      cnt_r <= bcd_clamp(load_val);
    end else if (en) begin
      cnt_r <= next_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt    = cnt_r;
  assign at_one = (cnt_r == 8'h01);

endmodule

// File: rtl/sec_timer_ctrl.sv
// Seconds timer: prescaler divides clk by DIV into count ticks, FSM sequences
// IDLE/RUN/PAUSE/DONE and drives the BCD seconds counter.
module sec_timer_ctrl
  import sec_timer_pkg::*;
#(
  parameter int FREQ_CLK = 24,
  parameter int DIV      = FREQ_CLK * 1000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic       pause,
  input  logic       clr,
  input  logic       mode,
  input  logic [7:0] preset,
  output logic [7:0] sec_bcd,
  output logic       tick,
  output logic       running,
  output logic       done
);

  localparam logic [24:0] PRESC_LAST = 25'(DIV - 1);

  state_t      state_r;
  logic [24:0] presc_r;
  logic        mode_r;
  logic        tick_r;
  logic        done_r;
  logic        running_r;

  logic        start_ok_s;
  logic        run_adv_s;
  logic        presc_wrap_s;
  logic        load_zero_s;
  logic [7:0]  load_val_s;
  logic        cnt_clr_s;
  logic        cnt_load_s;
  logic        cnt_en_s;
  logic        cnt_at_one_s;

  // Decode this cycle's command into counter controls (clr > start > pause)
  always_comb begin
    start_ok_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    run_adv_s    = (state_r == ST_RUN) && (start || !pause);
    presc_wrap_s = (presc_r == PRESC_LAST);
    load_val_s   = mode ? preset : 8'h00;
    load_zero_s  = mode && (bcd_clamp(preset) == 8'h00);
    cnt_clr_s    = 1'b0;
    cnt_load_s   = 1'b0;
    cnt_en_s     = 1'b0;
    if (clr) begin
      cnt_clr_s = 1'b1;
    end else if (start_ok_s) begin
      cnt_load_s = 1'b1;
    end else if (run_adv_s && presc_wrap_s) begin
      cnt_en_s = 1'b1;
    end else begin
      cnt_en_s = 1'b0;
    end
  end

  // Control FSM with prescaler and registered strobes
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r   <= ST_IDLE;
      presc_r   <= 25'd0;
      mode_r    <= 1'b0;
      tick_r    <= 1'b0;
      done_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      done_r <= 1'b0;
      if (clr) begin
        state_r   <= ST_IDLE;
        presc_r   <= 25'd0;
        running_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              mode_r  <= mode;
              presc_r <= 25'd0;
              // A down count that loads 00 has nothing to count
              if (load_zero_s) begin
                state_r   <= ST_DONE;
                done_r    <= 1'b1;
                running_r <= 1'b0;
              end else begin
                state_r   <= ST_RUN;
                running_r <= 1'b1;
              end
            end else begin
              state_r <= state_r;
            end
          end
          ST_RUN: begin
            if (run_adv_s) begin
              if (presc_wrap_s) begin
                presc_r <= 25'd0;
                tick_r  <= 1'b1;
                if (mode_r && cnt_at_one_s) begin
                  state_r   <= ST_DONE;
                  done_r    <= 1'b1;
                  running_r <= 1'b0;
                end else begin
                  state_r <= ST_RUN;
                end
              end else begin
                presc_r <= presc_r + 25'd1;
              end
            end else begin
              state_r   <= ST_PAUSE;
              running_r <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (start) begin
              state_r   <= ST_RUN;
              running_r <= 1'b1;
            end else begin
              state_r <= ST_PAUSE;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            presc_r   <= 25'd0;
            running_r <= 1'b0;
          end
        endcase
      end
    end
  end

  bcd_sec_cnt u_cnt (
    .clk      (clk),
    .res      (res),
    .clr      (cnt_clr_s),
    .load     (cnt_load_s),
    .load_val (load_val_s),
    .en       (cnt_en_s),
    .down     (mode_r),
    .cnt      (sec_bcd),
    .at_one   (cnt_at_one_s)
  );

  assign tick    = tick_r;
  assign done    = done_r;
  assign running = running_r;

endmodule
